// File: rtl/dof_pkg.sv
// Shared definitions for the decode/operand-fetch (DOF) stage:
// memory-data / branch-select encodings, the control half of the
// DOF/EXE pipeline register, and the bubble value for that control half.
package dof_pkg;

  // MD selects what EXE writes back: ALU result, loaded data or a flag.
  localparam logic [1:0] MD_ALU  = 2'b00;
  localparam logic [1:0] MD_LOAD = 2'b01;
  localparam logic [1:0] MD_FLAG = 2'b10;

  // BS selects the branch behaviour in EXE; NONE means fall through.
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_BZ   = 2'b01;
  localparam logic [1:0] BS_BRA  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  // Control fields carried in the DOF/EXE register. Widths do not depend
  // on any stage parameter, so this lives here; the datapath half of the
  // bundle (da, sh, busa, busb, pc) is declared in the stage itself.
  typedef struct packed {
    logic       rw;
    logic       ps;
    logic       mw;
    logic [1:0] md;
    logic [1:0] bs;
    logic [3:0] fs;
  } dof_ctrl_t;

  // A bubble must never write a register, write memory or branch.
  localparam dof_ctrl_t CTRL_BUBBLE = '{
    rw: 1'b0,
    ps: 1'b0,
    mw: 1'b0,
    md: MD_ALU,
    bs: BS_NONE,
    fs: 4'h0
  };

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding selector for one operand. Source 0 is the youngest
// (EXE) result and wins over every older source. Register 0 never matches.
module fwd_select #(
  parameter int DATA_BITS      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 2
) (
  input  logic [REG_ADDR_WIDTH-1:0]         i_addr,
  input  logic [NUM_FWD-1:0]                i_fwd_rw,
  input  logic [NUM_FWD-1:0]                i_fwd_load,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] i_fwd_da,
  input  logic [NUM_FWD*DATA_BITS-1:0]      i_fwd_data,
  output logic                              o_hit,
  output logic                              o_hit_load,
  output logic [DATA_BITS-1:0]              o_data
);

  // Scan oldest to youngest so the lowest matching index overwrites the rest.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_load = 1'b0;
    o_data     = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_rw[i] &&
          (i_fwd_da[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == i_addr) &&
          (i_addr != '0)) begin
        o_hit      = 1'b1;
        o_hit_load = i_fwd_load[i];
        o_data     = i_fwd_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: picks operands (PC, immediate, forwarded
// results or register file), detects load-use hazards, and registers the
// instruction into the DOF/EXE pipeline register behind valid/ready.
// Optional build macro: OFS_PERF_CNT_EN adds a saturating stall_count output.
module operand_fetch_stage
  import dof_pkg::*;
#(
  parameter int DATA_BITS      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 15,
  parameter int NUM_FWD        = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_BITS-1:0]              pc_min_one,
  input  logic                              dec_rw,
  input  logic                              dec_ps,
  input  logic                              dec_mw,
  input  logic                              dec_ma,
  input  logic                              dec_mb,
  input  logic                              dec_cs,
  input  logic [1:0]                        dec_md,
  input  logic [1:0]                        dec_bs,
  input  logic [3:0]                        dec_fs,
  input  logic [REG_ADDR_WIDTH-1:0]         dec_da,
  input  logic [REG_ADDR_WIDTH-1:0]         dec_aa,
  input  logic [REG_ADDR_WIDTH-1:0]         dec_ba,
  input  logic [IMM_WIDTH-1:0]              imm,
  input  logic [REG_ADDR_WIDTH-1:0]         sh_in,
  input  logic [DATA_BITS-1:0]              adata,
  input  logic [DATA_BITS-1:0]              bdata,
  input  logic [NUM_FWD-1:0]                fwd_rw,
  input  logic [NUM_FWD-1:0]                fwd_load,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_da,
  input  logic [NUM_FWD*DATA_BITS-1:0]      fwd_data,
  input  logic                              flush_n,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_BITS-1:0]              pc_min_two,
  output logic [DATA_BITS-1:0]              busa,
  output logic [DATA_BITS-1:0]              busb,
  output logic                              rw,
  output logic                              ps,
  output logic                              mw,
  output logic [1:0]                        md,
  output logic [1:0]                        bs,
  output logic [3:0]                        fs,
  output logic [REG_ADDR_WIDTH-1:0]         da,
  output logic [REG_ADDR_WIDTH-1:0]         sh,
`ifdef OFS_PERF_CNT_EN
  output logic [31:0]                       stall_count,
`endif
  output logic                              stall
);

  // Full DOF/EXE register: package control half plus parameter-sized datapath.
  typedef struct packed {
    dof_ctrl_t                 ctrl;
    logic [REG_ADDR_WIDTH-1:0] da;
    logic [REG_ADDR_WIDTH-1:0] sh;
    logic [DATA_BITS-1:0]      busa;
    logic [DATA_BITS-1:0]      busb;
    logic [DATA_BITS-1:0]      pc;
  } pipe_reg_t;

  localparam pipe_reg_t PIPE_BUBBLE = '{
    ctrl: CTRL_BUBBLE,
    da:   '0,
    sh:   '0,
    busa: '0,
    busb: '0,
    pc:   '0
  };

  pipe_reg_t            r_pipe;
  logic                 r_valid;
  pipe_reg_t            w_next;
  logic [DATA_BITS-1:0] w_imm_ext;
  logic [DATA_BITS-1:0] w_fwd_a_data;
  logic [DATA_BITS-1:0] w_fwd_b_data;
  logic                 w_hit_a;
  logic                 w_hit_a_load;
  logic                 w_hit_b;
  logic                 w_hit_b_load;
  logic                 w_adv;
  logic                 w_stall;
  logic                 w_take;

  fwd_select #(
    .DATA_BITS      (DATA_BITS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD        (NUM_FWD)
  ) u_fwd_a (
    .i_addr     (dec_aa),
    .i_fwd_rw   (fwd_rw),
    .i_fwd_load (fwd_load),
    .i_fwd_da   (fwd_da),
    .i_fwd_data (fwd_data),
    .o_hit      (w_hit_a),
    .o_hit_load (w_hit_a_load),
    .o_data     (w_fwd_a_data)
  );

  fwd_select #(
    .DATA_BITS      (DATA_BITS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD        (NUM_FWD)
  ) u_fwd_b (
    .i_addr     (dec_ba),
    .i_fwd_rw   (fwd_rw),
    .i_fwd_load (fwd_load),
    .i_fwd_da   (fwd_da),
    .i_fwd_data (fwd_data),
    .o_hit      (w_hit_b),
    .o_hit_load (w_hit_b_load),
    .o_data     (w_fwd_b_data)
  );

  // Extend the immediate: CS chooses sign extension, otherwise zero fill.
  always_comb begin
    if (dec_cs) begin
      w_imm_ext = {{(DATA_BITS-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    end else begin
      w_imm_ext = {{(DATA_BITS-IMM_WIDTH){1'b0}}, imm};
    end
  end

  // Handshake and hazard: a load-use stall only matters for an operand that
  // actually comes from a forward source, and a flush overrides it.
  always_comb begin
    w_adv   = out_ready | ~r_valid;
    w_stall = in_valid & flush_n &
              ((~dec_ma & w_hit_a & w_hit_a_load) |
               (~dec_mb & w_hit_b & w_hit_b_load));
    w_take  = in_valid & flush_n & ~w_stall;
    if (!flush_n) begin
      in_ready = w_adv;
    end else begin
      in_ready = w_adv & ~w_stall;
    end
  end

  // Assemble the candidate register contents for an accepted instruction.
  always_comb begin
    w_next         = PIPE_BUBBLE;
    w_next.ctrl.rw = dec_rw;
    w_next.ctrl.ps = dec_ps;
    w_next.ctrl.mw = dec_mw;
    w_next.ctrl.md = dec_md;
    w_next.ctrl.bs = dec_bs;
    w_next.ctrl.fs = dec_fs;
    w_next.da      = dec_da;
    w_next.sh      = sh_in;
    w_next.pc      = pc_min_one;
    if (dec_ma) begin
      w_next.busa = pc_min_one;
    end else if (w_hit_a) begin
      w_next.busa = w_fwd_a_data;
    end else begin
      w_next.busa = adata;
    end
    if (dec_mb) begin
      w_next.busb = w_imm_ext;
    end else if (w_hit_b) begin
      w_next.busb = w_fwd_b_data;
    end else begin
      w_next.busb = bdata;
    end
  end

  // Pipeline register: load the instruction or a bubble when EXE can advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe  <= '0;
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_take;
      r_pipe  <= w_take ? w_next : PIPE_BUBBLE;
    end
  end

`ifdef OFS_PERF_CNT_EN
  logic [31:0] r_stall_count;

  // Count stalled cycles, pinning at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign stall      = w_stall;
  assign out_valid  = r_valid;
  assign rw         = r_pipe.ctrl.rw;
  assign ps         = r_pipe.ctrl.ps;
  assign mw         = r_pipe.ctrl.mw;
  assign md         = r_pipe.ctrl.md;
  assign bs         = r_pipe.ctrl.bs;
  assign fs         = r_pipe.ctrl.fs;
  assign da         = r_pipe.da;
  assign sh         = r_pipe.sh;
  assign busa       = r_pipe.busa;
  assign busb       = r_pipe.busb;
  assign pc_min_two = r_pipe.pc;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural model of the stage.
// Optional build macro: OFS_PERF_CNT_EN (stall_count port and its check).
module tb_operand_fetch_stage;

  localparam int DB  = 32;
  localparam int RAW = 5;
  localparam int IW  = 15;
  localparam int NF  = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DB-1:0]   pc_min_one;
  logic            dec_rw, dec_ps, dec_mw, dec_ma, dec_mb, dec_cs;
  logic [1:0]      dec_md, dec_bs;
  logic [3:0]      dec_fs;
  logic [RAW-1:0]  dec_da, dec_aa, dec_ba;
  logic [IW-1:0]   imm;
  logic [RAW-1:0]  sh_in;
  logic [DB-1:0]   adata, bdata;
  logic [NF-1:0]   fwd_rw, fwd_load;
  logic [RAW-1:0]  t_fwd_da [NF];
  logic [DB-1:0]   t_fwd_data [NF];
  logic [NF*RAW-1:0] fwd_da;
  logic [NF*DB-1:0]  fwd_data;
  logic            flush_n;
  logic            out_valid;
  logic            out_ready;
  logic [DB-1:0]   pc_min_two, busa, busb;
  logic            rw, ps, mw;
  logic [1:0]      md, bs;
  logic [3:0]      fs;
  logic [RAW-1:0]  da, sh;
  logic            stall;
`ifdef OFS_PERF_CNT_EN
  logic [31:0]     stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  assign fwd_da   = {t_fwd_da[1], t_fwd_da[0]};
  assign fwd_data = {t_fwd_data[1], t_fwd_data[0]};

  operand_fetch_stage #(
    .DATA_BITS      (DB),
    .REG_ADDR_WIDTH (RAW),
    .IMM_WIDTH      (IW),
    .NUM_FWD        (NF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_min_one (pc_min_one),
    .dec_rw     (dec_rw),
    .dec_ps     (dec_ps),
    .dec_mw     (dec_mw),
    .dec_ma     (dec_ma),
    .dec_mb     (dec_mb),
    .dec_cs     (dec_cs),
    .dec_md     (dec_md),
    .dec_bs     (dec_bs),
    .dec_fs     (dec_fs),
    .dec_da     (dec_da),
    .dec_aa     (dec_aa),
    .dec_ba     (dec_ba),
    .imm        (imm),
    .sh_in      (sh_in),
    .adata      (adata),
    .bdata      (bdata),
    .fwd_rw     (fwd_rw),
    .fwd_load   (fwd_load),
    .fwd_da     (fwd_da),
    .fwd_data   (fwd_data),
    .flush_n    (flush_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_min_two (pc_min_two),
    .busa       (busa),
    .busb       (busb),
    .rw         (rw),
    .ps         (ps),
    .mw         (mw),
    .md         (md),
    .bs         (bs),
    .fs         (fs),
    .da         (da),
    .sh         (sh),
`ifdef OFS_PERF_CNT_EN
    .stall_count(stall_count),
`endif
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit        rw, ps, mw;
    bit [1:0]  md, bs;
    bit [3:0]  fs;
    bit [4:0]  da, sh;
    bit [31:0] a, b, pc;
  } mstate_t;

  mstate_t   m;
  bit        m_full = 1'b0;
  bit        m_live = 1'b0;
  bit [31:0] m_cnt  = 32'd0;

  function automatic bit [31:0] modelImm();
    bit [31:0] v;
    v = 32'(imm);
    if (dec_cs && imm[IW-1]) v = v | ~((32'd1 << IW) - 32'd1);
    return v;
  endfunction

  // Operand value from the priority list; ld says it comes from a pending load.
  function automatic void resolve(input bit ovr, input bit [31:0] ovr_val,
                                  input bit [4:0] addr, input bit [31:0] rf,
                                  output bit [31:0] val, output bit ld);
    val = rf;
    ld  = 1'b0;
    if (ovr) begin
      val = ovr_val;
    end else if (addr != 5'd0) begin
      for (int i = 0; i < NF; i++) begin
        if (fwd_rw[i] && t_fwd_da[i] == addr) begin
          val = t_fwd_data[i];
          ld  = fwd_load[i];
          break;
        end
      end
    end
  endfunction

  function automatic bit modelStall();
    bit [31:0] a, b;
    bit la, lb;
    resolve(dec_ma, pc_min_one, dec_aa, adata, a, la);
    resolve(dec_mb, modelImm(), dec_ba, bdata, b, lb);
    return in_valid && flush_n && (la || lb);
  endfunction

  // Model state update on every rising edge from the inputs then present.
  always @(posedge clk) begin
    bit [31:0] a, b;
    bit la, lb, st;
    if (!rst_n) begin
      m      = '{default: 0};
      m_full = 1'b1;
      m_live = 1'b1;
      m_cnt  = 32'd0;
    end else begin
      resolve(dec_ma, pc_min_one, dec_aa, adata, a, la);
      resolve(dec_mb, modelImm(), dec_ba, bdata, b, lb);
      st = in_valid && flush_n && (la || lb);
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (out_ready || !m.v) begin
        if (in_valid && flush_n && !st) begin
          m = '{v: 1'b1, rw: dec_rw, ps: dec_ps, mw: dec_mw, md: dec_md,
                bs: dec_bs, fs: dec_fs, da: dec_da, sh: sh_in,
                a: a, b: b, pc: pc_min_one};
          m_full = 1'b1;
        end else begin
          m.v    = 1'b0;
          m.rw   = 1'b0;
          m.mw   = 1'b0;
          m.bs   = 2'b00;
          m_full = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    bit st, ir, adv;
    if (m_live) begin
      st  = modelStall();
      adv = out_ready || !m.v;
      ir  = flush_n ? (adv && !st) : adv;
      checkOutput("m_stall", 32'(stall), 32'(st));
      checkOutput("m_in_ready", 32'(in_ready), 32'(ir));
      checkOutput("m_out_valid", 32'(out_valid), 32'(m.v));
      checkOutput("m_rw", 32'(rw), 32'(m.rw));
      checkOutput("m_mw", 32'(mw), 32'(m.mw));
      checkOutput("m_bs", 32'(bs), 32'(m.bs));
      if (m_full) begin
        checkOutput("m_ps", 32'(ps), 32'(m.ps));
        checkOutput("m_md", 32'(md), 32'(m.md));
        checkOutput("m_fs", 32'(fs), 32'(m.fs));
        checkOutput("m_da", 32'(da), 32'(m.da));
        checkOutput("m_sh", 32'(sh), 32'(m.sh));
        checkOutput("m_busa", busa, m.a);
        checkOutput("m_busb", busb, m.b);
        checkOutput("m_pc", pc_min_two, m.pc);
      end
`ifdef OFS_PERF_CNT_EN
      checkOutput("m_stall_count", stall_count, m_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic setIdle();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_n = 1'b1;
    pc_min_one = 32'h0; dec_rw = 0; dec_ps = 0; dec_mw = 0; dec_ma = 0;
    dec_mb = 0; dec_cs = 0; dec_md = 2'b00; dec_bs = 2'b00; dec_fs = 4'h0;
    dec_da = 0; dec_aa = 0; dec_ba = 0; imm = '0; sh_in = 0;
    adata = 32'h0; bdata = 32'h0; fwd_rw = '0; fwd_load = '0;
    for (int i = 0; i < NF; i++) begin
      t_fwd_da[i] = '0;
      t_fwd_data[i] = '0;
    end
  endtask

  // Advance one clock; inputs change 2 time units after each rising edge.
  task automatic applyStimulus(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [31:0] held_a;
    setIdle();

    // Reset then idle
    rst_n = 1'b0;
    applyStimulus(2);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busa", busa, 32'd0);
    checkOutput("rst_pc", pc_min_two, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // EXE forward beats older source on the same register
    in_valid = 1; dec_rw = 1; dec_da = 5'd9; dec_aa = 5'd3; dec_ba = 5'd4;
    adata = 32'hAAAA; bdata = 32'hBBBB; pc_min_one = 32'h100; dec_fs = 4'h5;
    fwd_rw = 2'b11; t_fwd_da[0] = 5'd3; t_fwd_da[1] = 5'd3;
    t_fwd_data[0] = 32'h11; t_fwd_data[1] = 32'h22;
    applyStimulus();
    checkOutput("fwd_busa", busa, 32'h11);
    checkOutput("fwd_busb_rf", busb, 32'hBBBB);
    checkOutput("fwd_out_valid", 32'(out_valid), 32'd1);
    checkOutput("fwd_pc", pc_min_two, 32'h100);

    // Sign-extended immediate; R0 never forwarded
    dec_mb = 1; dec_cs = 1; imm = 15'h7FFF; dec_aa = 5'd0; adata = 32'h1234;
    fwd_rw = 2'b01; t_fwd_da[0] = 5'd0;
    applyStimulus();
    checkOutput("imm_sext", busb, 32'hFFFF_FFFF);
    checkOutput("r0_busa", busa, 32'h1234);
    dec_cs = 0; imm = 15'h4001;
    applyStimulus();
    checkOutput("imm_zext", busb, 32'h0000_4001);

    // Load-use on B stalls, then resolves next cycle
    dec_mb = 0; dec_ma = 1; pc_min_one = 32'h200; dec_ba = 5'd5;
    fwd_rw = 2'b01; fwd_load = 2'b01; t_fwd_da[0] = 5'd5; t_fwd_data[0] = 32'h0;
    #1;
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_in_ready", 32'(in_ready), 32'd0);
    applyStimulus();
    checkOutput("lu_bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("lu_bubble_rw", 32'(rw), 32'd0);
    fwd_load = 2'b00; t_fwd_data[0] = 32'h55;
    #1;
    checkOutput("lu_release_stall", 32'(stall), 32'd0);
    applyStimulus();
    checkOutput("lu_busb", busb, 32'h55);
    checkOutput("lu_busa_pc", busa, 32'h200);

    // Younger non-load match shadows older load
    fwd_rw = 2'b11; fwd_load = 2'b10; t_fwd_da[1] = 5'd5; t_fwd_data[1] = 32'h99;
    t_fwd_data[0] = 32'h66;
    #1;
    checkOutput("shadow_stall", 32'(stall), 32'd0);
    applyStimulus();
    checkOutput("shadow_busb", busb, 32'h66);

    // Flush during a load-use stall
    fwd_load = 2'b01; flush_n = 0; dec_mw = 1; dec_bs = 2'b10;
    #1;
    checkOutput("fl_stall", 32'(stall), 32'd0);
    checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
    applyStimulus();
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_rw", 32'(rw), 32'd0);
    checkOutput("fl_mw", 32'(mw), 32'd0);
    checkOutput("fl_bs", 32'(bs), 32'd0);
    flush_n = 1; fwd_load = 2'b00; fwd_rw = 2'b00; dec_mw = 0; dec_bs = 0;

    // Backpressure holds the register, release loads the next one at once
    dec_ma = 0; dec_aa = 5'd7; adata = 32'hCAFE;
    applyStimulus();
    held_a = 32'hCAFE;
    checkOutput("bp_first", busa, held_a);
    out_ready = 0; adata = 32'hBEEF; dec_da = 5'd2;
    #1;
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("bp_hold_busa", busa, held_a);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    applyStimulus();
    checkOutput("bp_new_busa", busa, 32'hBEEF);

    // Reset while stalled drops the instruction
    fwd_rw = 2'b01; fwd_load = 2'b01; t_fwd_da[0] = 5'd7; rst_n = 0;
    applyStimulus();
    checkOutput("rst_stall_valid", 32'(out_valid), 32'd0);
    rst_n = 1;
    applyStimulus(2);

    // Mixed vectors over a small register range, checked by the model
    for (int k = 0; k < 80; k++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush_n = 1'($urandom_range(0, 7) != 0);
      {dec_rw, dec_ps, dec_mw, dec_ma, dec_mb, dec_cs} = 6'($urandom);
      dec_md = 2'($urandom); dec_bs = 2'($urandom); dec_fs = 4'($urandom);
      dec_da = 5'($urandom); dec_aa = 5'($urandom_range(0, 3));
      dec_ba = 5'($urandom_range(0, 3)); imm = 15'($urandom);
      sh_in = 5'($urandom); adata = $urandom; bdata = $urandom;
      pc_min_one = $urandom; fwd_rw = 2'($urandom); fwd_load = 2'($urandom);
      for (int i = 0; i < NF; i++) begin
        t_fwd_da[i] = 5'($urandom_range(0, 3));
        t_fwd_data[i] = $urandom;
      end
      applyStimulus();
    end

    setIdle();
    applyStimulus(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Parametrised successor to the decode/operand-fetch stage of the MIPS-style pipeline.
- Takes decoded control fields, register-file read data, PC+1 and NUM_FWD forwarding sources, selects operands, and extends the immediate.
- Detects load-use hazards and stalls for them; handles flush.
- Registers everything into the DOF/EXE pipeline register behind a valid/ready handshake.

Parameters:
- DATA_BITS, 32, datapath width.
- REG_ADDR_WIDTH, 5, register address width.
- IMM_WIDTH, 15, immediate field width (< DATA_BITS).
- NUM_FWD, 2, forwarding sources; index 0 = EXE (nearest), higher = older stages.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts the instruction this cycle
- pc_min_one  in  DATA_BITS  PC+1 of the incoming instruction
- dec_rw, dec_ps, dec_mw, dec_ma, dec_mb, dec_cs  in  1 each  decoder controls
- dec_md, dec_bs  in  2 each  decoder controls
- dec_fs  in  4  function select
- dec_da, dec_aa, dec_ba  in  REG_ADDR_WIDTH  destination / source A / source B addresses
- imm  in  IMM_WIDTH  immediate field
- sh_in  in  REG_ADDR_WIDTH  shift amount
- adata, bdata  in  DATA_BITS  register-file read data for dec_aa / dec_ba
- fwd_rw  in  NUM_FWD  source writes a register
- fwd_load  in  NUM_FWD  source result not yet available (load in flight)
- fwd_da  in  NUM_FWD*REG_ADDR_WIDTH  source destinations, packed, index 0 in LSBs
- fwd_data  in  NUM_FWD*DATA_BITS  source results, packed
- flush_n  in  1  active-low kill of the current DOF instruction
- out_valid  out  1  pipeline register holds a live instruction
- out_ready  in  1  EXE accepts
- pc_min_two, busa, busb  out  DATA_BITS  registered
- rw, ps, mw  out  1  registered controls
- md, bs  out  2  registered controls
- fs  out  4  registered function select
- da, sh  out  REG_ADDR_WIDTH  registered
- stall  out  1  combinational load-use stall indication

Behaviour:
- Reset (rst_n=0 at posedge): every registered output = 0, out_valid = 0. Reset mid-stall drops the stalled instruction.
- Advance condition: adv = out_ready | ~out_valid. Register updates only when adv=1; otherwise all outputs hold.
- Immediate extension:
  - dec_cs=1: sign-extend imm to DATA_BITS.
  - dec_cs=0: zero-extend.
- Operand A priority:
  1. dec_ma=1 → pc_min_one.
  2. Else the lowest index i with fwd_rw[i]=1, fwd_da[i]==dec_aa and dec_aa!=0 → fwd_data[i].
  3. Else adata.
- Operand B: same priority, with dec_mb/extended immediate replacing dec_ma/pc_min_one, and dec_ba/bdata replacing dec_aa/adata.
- Register 0 is never forwarded.
- Hazard: stall=1 when in_valid, flush_n=1, and the selected forward source for a used operand (not overridden by MA/MB) has fwd_load=1.
  - Only the first matching index counts; a younger non-load match shadows an older load.
- Stall with adv=1: a bubble is loaded (out_valid=0; rw, mw, bs = 0). in_ready=0.
- Flush (flush_n=0) has priority over stall:
  - in_ready=adv.
  - With adv=1, a bubble is loaded and the instruction is dropped.
- Normal case: in_ready = adv & ~stall. On in_valid & in_ready, all decoded fields, operands, pc_min_one→pc_min_two and sh_in→sh are loaded; out_valid=1.
- If in_valid=0 and adv=1, a bubble is loaded.
- Latency: 1 cycle from acceptance to out_valid.
- Back-to-back throughput: 1 instruction/cycle.

Optional Feature:
- Macro OFS_PERF_CNT_EN.
- Defined: adds output stall_count, 32-bit. Reset 0; +1 every cycle stall=1; saturates at 0xFFFFFFFF.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package dof_pkg:
  - MD/BS encodings (MD_LOAD = 2'b01).
  - Pipeline-register bundle struct (rw, da, md, bs, ps, mw, fs, sh, busa, busb, pc).
  - BUBBLE constant.
- Sub-module fwd_select: one instance per operand.
  - Priority match over NUM_FWD sources.
  - Outputs hit, hit_load, selected data.

Test Plan:
- Reset then idle: rst_n=0 two cycles → all outputs 0, out_valid=0, in_ready=1.
- EXE forward priority: fwd_rw=2'b11, fwd_da={R3,R3}, fwd_data={0x22,0x11}, dec_aa=R3, ma=0 → next cycle busa=0x11, out_valid=1.
- Immediate and R0: dec_mb=1, dec_cs=1, imm=15'h7FFF → busb=0xFFFFFFFF. dec_aa=0 with fwd_da[0]=0 → busa=adata.
- Load-use: fwd_load[0]=1, fwd_da[0]=R5, dec_ba=R5, mb=0 → stall=1, in_ready=0, bubble loaded. Next cycle fwd_load=0, data 0x55 → busb=0x55.
- Flush during stall: load-use condition plus flush_n=0 → in_ready=1, bubble loaded with rw=mw=0, bs=0. Stall counter (if enabled) still increments only if stall=1 (here 0).
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → outputs stable, in_ready=0. Release → new instruction loads in the same cycle.
